fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  Pointer/flag controller for the 8x10 FIFO storage array (memory). Sits directly upstream:
//  turns push/pop requests into write_addr/read_addr/write_enable/read_enable for memory.
//  Tracks occupancy and drives full/empty/almost flags for the producer and consumer.
//  Data does not pass through this block; Fifo_Data_in/Fifo_Data_out connect straight to memory.
// PARAMETERS
//  MEM_LENGHT  8  FIFO depth in entries; must be a power of 2.
//  ADDR_W      3  Address width, log2(MEM_LENGHT).
//  CNT_W       4  Occupancy counter width, ADDR_W+1 (holds 0..MEM_LENGHT).
// PORTS
//  clk             in   1       Single clock; all state updates on the posedge.
//  reset           in   1       Synchronous, active-high reset.
//  push            in   1       Write request; producer presents Fifo_Data_in to memory in the same cycle.
//  pop             in   1       Read request; data appears on memory Fifo_Data_out on the next posedge.
//  almost_full_thr in   CNT_W   Raises almost_full when count >= value. Sampled in ST_INIT only.
//  almost_empty_thr in  CNT_W   Raises almost_empty when count <= value. Sampled in ST_INIT only.
//  write_enable    out  1       To memory. Combinational: push & accepted.
//  read_enable     out  1       To memory. Combinational: pop & accepted.
//  write_addr      out  ADDR_W  To memory. Registered write pointer.
//  read_addr       out  ADDR_W  To memory. Registered read pointer.
//  fifo_count      out  CNT_W   Registered occupancy, 0..MEM_LENGHT.
//  full, empty     out  1       Registered flags, decoded from the FSM state.
//  almost_full, almost_empty  out 1  Registered; compare against the latched thresholds.
//  fifo_error      out  1       Present only when FIFO_ERROR_FLAGS_EN is defined.
// BEHAVIOUR
//  Reset (reset=1 at posedge):
//   - Pointers=0, count=0, FSM=ST_INIT, empty=1.
//   - full=0, almost_full=0, almost_empty=1, fifo_error=0.
//   - Enables are 0 while reset=1.
//   - Reset mid-operation discards all occupancy; memory contents are left untouched.
//  FSM states:
//   - ST_INIT: lasts 1 cycle after reset; latches both thresholds; push/pop ignored (enables 0).
//     Moves to ST_EMPTY.
//   - ST_EMPTY: count==0.
//   - ST_MID: 0<count<MEM_LENGHT.
//   - ST_FULL: count==MEM_LENGHT.
//   - Next state is computed from next_count.
//  Acceptance:
//   - wr_ok = push & (state!=ST_FULL) & (state!=ST_INIT).
//   - rd_ok = pop & (state!=ST_EMPTY) & (state!=ST_INIT).
//   - Push+pop in ST_FULL: pop accepted, push rejected (wr_ptr==rd_ptr, avoids a same-address hazard).
//   - Push+pop in ST_EMPTY: push accepted, pop rejected (no read-through).
//   - Push+pop in ST_MID: both accepted; count unchanged; both pointers advance.
//  Pointer/count update:
//   - wr_ok: write_addr <= write_addr+1, wraps mod MEM_LENGHT (7->0).
//   - rd_ok: read_addr <= read_addr+1, same wrap.
//   - count <= count + wr_ok - rd_ok; never leaves 0..MEM_LENGHT.
//  Flags and latency:
//   - All flags update on the same edge as count and reflect next_count.
//   - Flags are valid the cycle after the accepted op.
//   - Read data latency: 1 cycle after read_enable (set by memory).
// CONFIGURATION
//  FIFO_ERROR_FLAGS_EN defined:
//   - fifo_error port exists.
//   - Sets (sticky) on a rejected push in ST_FULL or a rejected pop in ST_EMPTY.
//   - Requests made during ST_INIT do not set it.
//   - Cleared only by reset.
//  Not defined: port absent; rejected requests are dropped silently.
// TESTING
//  1. reset 2 cycles, release -> INIT 1 cycle then empty=1, full=0, count=0, addrs=0, enables 0 during INIT.
//  2. 8 pushes (data 0x001..0x008) -> full=1, count=8, write_addr=0 (wrapped);
//     8 pops -> Fifo_Data_out 0x001..0x008 in order, empty=1.
//  3. Thresholds 6/2: push 6 -> almost_full=1 at count 6;
//     pop to count 2 -> almost_empty=1, almost_full=0.
//  4. Full + push&pop -> read_enable=1, write_enable=0, count=7;
//     empty + push&pop -> write_enable=1, read_enable=0, count=1.
//  5. Count 4, push&pop for 10 cycles -> count stays 4; both addrs advance 10 mod 8 (+2);
//     data order preserved.
//  6. FIFO_ERROR_FLAGS_EN: push while full -> fifo_error=1 next cycle, stays 1 after pops;
//     reset -> 0. Without macro: count stays 8, no port.

Source files
------------

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//   Pointer/flag controller for an external MEM_LENGHT x N FIFO storage array.
//   Converts push/pop requests into write/read addresses and enables for the
//   memory and keeps the occupancy count plus full/empty/almost flags. No data
//   passes through this block.
//
//   Optional feature macro: FIFO_ERROR_FLAGS_EN
//     defined   -> fifo_error port exists; sticky flag set by a rejected push
//                  while full or a rejected pop while empty, cleared by reset.
//     undefined -> no fifo_error port; rejected requests are dropped silently.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   push, pop         producer write request / consumer read request
//   almost_full_thr   almost_full when count >= thr (latched in ST_INIT only)
//   almost_empty_thr  almost_empty when count <= thr (latched in ST_INIT only)
//   write_enable      to memory, combinational (push accepted)
//   read_enable       to memory, combinational (pop accepted)
//   write_addr        to memory, registered write pointer
//   read_addr         to memory, registered read pointer
//   fifo_count        registered occupancy 0..MEM_LENGHT
//   full, empty       registered flags decoded from the next FSM state
//   almost_full/empty registered threshold compares on the next count
//   fifo_error        sticky error flag (FIFO_ERROR_FLAGS_EN only)
// -----------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int MEM_LENGHT = 8,
  parameter int ADDR_W     = 3,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [CNT_W-1:0]  almost_full_thr,
  input  logic [CNT_W-1:0]  almost_empty_thr,
  output logic              write_enable,
  output logic              read_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W-1:0] read_addr,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
`ifdef FIFO_ERROR_FLAGS_EN
  output logic              almost_empty,
  output logic              fifo_error
`else
  output logic              almost_empty
`endif
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_EMPTY = 2'd1,
    ST_MID   = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_FULL_CNT = CNT_W'(MEM_LENGHT);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_af_thr;
  logic [CNT_W-1:0]  r_ae_thr;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [CNT_W-1:0]  w_next_count;
  logic [CNT_W-1:0]  w_af_thr;
  logic [CNT_W-1:0]  w_ae_thr;

  // Acceptance. Gating with reset keeps the memory enables quiet while the
  // block is being reset, even though the state is only cleared at the edge.
  // In ST_FULL the pointers are equal, so a simultaneous push is refused to
  // avoid writing the slot being read; in ST_EMPTY the pop is refused so there
  // is no read-through of the word being written.
  always_comb begin
    w_wr_ok = push & ~reset & (r_state != ST_FULL)  & (r_state != ST_INIT);
    w_rd_ok = pop  & ~reset & (r_state != ST_EMPTY) & (r_state != ST_INIT);
  end

  always_comb begin
    w_next_count = r_count + CNT_W'(w_wr_ok) - CNT_W'(w_rd_ok);
    if (w_next_count == '0)
      w_next_state = ST_EMPTY;
    else if (w_next_count == LP_FULL_CNT)
      w_next_state = ST_FULL;
    else
      w_next_state = ST_MID;
  end

  // The thresholds are being latched on the INIT edge, so the flags computed
  // on that same edge must use the live inputs rather than the stale latches.
  always_comb begin
    w_af_thr = (r_state == ST_INIT) ? almost_full_thr  : r_af_thr;
    w_ae_thr = (r_state == ST_INIT) ? almost_empty_thr : r_ae_thr;
  end

`ifdef FIFO_ERROR_FLAGS_EN
  logic r_err;
  logic w_err_evt;

  // A push refused only because the FIFO is full, or a pop refused only
  // because it is empty. Requests during ST_INIT are ignored entirely.
  always_comb begin
    w_err_evt = ~reset & ((push & (r_state == ST_FULL)) |
                          (pop  & (r_state == ST_EMPTY)));
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_err_evt)
      r_err <= 1'b1;
  end

  assign fifo_error = r_err;
`endif

  // FSM plus all registered outputs. Every flag follows next_count so it is
  // valid the cycle after the accepted operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_INIT;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_af_thr <= '0;
      r_ae_thr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_af_thr <= almost_full_thr;
          r_ae_thr <= almost_empty_thr;
          r_state  <= ST_EMPTY;
        end
        default: r_state <= w_next_state;
      endcase

      // Power-of-two depth: pointers wrap naturally at ADDR_W bits.
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;

      r_count <= w_next_count;
      r_full  <= (w_next_state == ST_FULL);
      r_empty <= (w_next_state == ST_EMPTY);
      r_af    <= (w_next_count >= w_af_thr);
      r_ae    <= (w_next_count <= w_ae_thr);
    end
  end

  assign write_enable = w_wr_ok;
  assign read_enable  = w_rd_ok;
  assign write_addr   = r_wr_ptr;
  assign read_addr    = r_rd_ptr;
  assign fifo_count   = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: directed steps followed by randomized push/pop,
// checked against a queue-based reference model and a small behavioural
// memory that stands in for the 8x10 storage array.
module tb_fifo_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop;
  logic [3:0] almost_full_thr, almost_empty_thr;
  logic       write_enable, read_enable;
  logic [2:0] write_addr, read_addr;
  logic [3:0] fifo_count;
  logic       full, empty, almost_full, almost_empty;
`ifdef FIFO_ERROR_FLAGS_EN
  logic       fifo_error;
`endif

  logic [9:0] din, dout;
  logic [9:0] mem [DEPTH];

  int vectors = 0;
  int errs    = 0;

  // reference model state
  logic [9:0] que[$];
  bit         m_init;
  int         m_wp, m_rp, m_aft, m_aet;
  bit         m_err;

  always #5 clk = ~clk;

  fifo_ctrl #(.MEM_LENGHT(8), .ADDR_W(3), .CNT_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .push             (push),
    .pop              (pop),
    .almost_full_thr  (almost_full_thr),
    .almost_empty_thr (almost_empty_thr),
    .write_enable     (write_enable),
    .read_enable      (read_enable),
    .write_addr       (write_addr),
    .read_addr        (read_addr),
    .fifo_count       (fifo_count),
    .full             (full),
    .empty            (empty),
    .almost_full      (almost_full),
`ifdef FIFO_ERROR_FLAGS_EN
    .almost_empty     (almost_empty),
    .fifo_error       (fifo_error)
`else
    .almost_empty     (almost_empty)
`endif
  );

  // Storage array: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (write_enable) mem[write_addr] <= din;
    if (read_enable)  dout <= mem[read_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = que.size();
    chk("fifo_count",   fifo_count,   n);
    chk("full",         full,         (n == DEPTH));
    chk("empty",        empty,        (n == 0));
    chk("almost_full",  almost_full,  (n >= m_aft));
    chk("almost_empty", almost_empty, (n <= m_aet));
    chk("write_addr",   write_addr,   m_wp % DEPTH);
    chk("read_addr",    read_addr,    m_rp % DEPTH);
`ifdef FIFO_ERROR_FLAGS_EN
    chk("fifo_error",   fifo_error,   m_err);
`endif
  endtask

  // One clock of stimulus: check the combinational enables, clock, then check
  // read data and all registered outputs against the model.
  task automatic step(input logic p, input logic q, input logic [9:0] d);
    bit wr, rd;
    int n;
    logic [9:0] exp_d;
    push = p; pop = q; din = d;
    #1;
    n  = que.size();
    wr = p && !m_init && (n < DEPTH);
    rd = q && !m_init && (n > 0);
    chk("write_enable", write_enable, wr);
    chk("read_enable",  read_enable,  rd);
    if (!m_init && ((p && n == DEPTH) || (q && n == 0))) m_err = 1'b1;
    if (m_init) begin
      m_aft = almost_full_thr;
      m_aet = almost_empty_thr;
    end
    @(posedge clk); #1;
    if (rd) begin
      exp_d = que.pop_front();
      chk("read_data", dout, exp_d);
      m_rp++;
    end
    if (wr) begin
      que.push_back(d);
      m_wp++;
    end
    m_init = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input logic [3:0] aft, input logic [3:0] aet);
    almost_full_thr = aft; almost_empty_thr = aet;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push = 1'b1; pop = 1'b1; din = 10'h3ff;
      #1;
      chk("we_in_reset", write_enable, 1'b0);
      chk("re_in_reset", read_enable,  1'b0);
      @(posedge clk); #1;
    end
    que.delete();
    m_wp = 0; m_rp = 0; m_err = 1'b0; m_init = 1'b1;
    chk("rst_count", fifo_count,   0);
    chk("rst_empty", empty,        1'b1);
    chk("rst_full",  full,         1'b0);
    chk("rst_af",    almost_full,  1'b0);
    chk("rst_ae",    almost_empty, 1'b1);
    chk("rst_waddr", write_addr,   0);
    chk("rst_raddr", read_addr,    0);
`ifdef FIFO_ERROR_FLAGS_EN
    chk("rst_err",   fifo_error,   1'b0);
`endif
    reset = 1'b0;
    // INIT cycle: requests must be ignored.
    step(1'b1, 1'b1, 10'h155);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
    almost_full_thr = 4'd6; almost_empty_thr = 4'd2;
    @(posedge clk); #1;

    // reset and INIT
    do_reset(4'd6, 4'd2);
    // thresholds must not be re-sampled after INIT
    almost_full_thr = 4'd1; almost_empty_thr = 4'd7;

    // fill with 1..8, push while full (rejected), then drain in order
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 10'(i));
    chk("full_waddr_wrap", write_addr, 0);
    step(1'b1, 1'b0, 10'h0aa);
    chk("count_stays_full", fifo_count, 8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 10'h000);
    step(1'b0, 1'b1, 10'h000);                 // pop while empty

    // almost thresholds 6/2: up to 6, down to 2
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 10'(16 + i));
    chk("af_at_6", almost_full, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 10'h000);
    chk("ae_at_2", almost_empty, 1'b1);
    chk("af_off_at_2", almost_full, 1'b0);

    // push&pop while full, then while empty
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 10'(32 + i));
    step(1'b1, 1'b1, 10'h1ff);
    chk("pp_full_count", fifo_count, 7);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 10'h000);
    step(1'b1, 1'b1, 10'h2cc);
    chk("pp_empty_count", fifo_count, 1);

    // steady push&pop at count 4
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'(48 + i));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 10'(64 + i));
    chk("steady_count", fifo_count, 4);

    // reset mid-operation clears occupancy and error
    do_reset(4'd7, 4'd1);

    // randomized phases with random thresholds and push/pop bias
    for (int r = 0; r < 4; r++) begin
      do_reset(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
      for (int i = 0; i < 150; i++) begin
        if ((i % 37) == 0) begin
          almost_full_thr  = 4'($urandom);
          almost_empty_thr = 4'($urandom);
        end
        step(1'($urandom_range(0, 99) < 30 + 15 * r),
             1'($urandom_range(0, 99) < 70 - 15 * r),
             10'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
